// File: rtl/kb_io_ctrl.sv
// ---------------------------------------------------------------------------
// kb_io_ctrl
//   Memory-mapped I/O controller that sequences keyboard_buf for the Y86 CPU.
//   Decodes a 4-register window at BASE_ADDR and turns CPU reads and writes
//   into single-cycle KB_read_en / KB_clear pulses. Counts characters that
//   arrive while the buffer is full and can raise a keyboard interrupt.
//
//   Register map (offset from BASE_ADDR):
//     +0 STATUS (RO)  {4'b0, irq_pend, ovf_flag, buf_full, KB_status}
//     +1 DATA   (RO)  {1'b0, KB_data}, pops the buffer; 8'h00 when empty
//     +2 CTRL   (W)   bit0 flush, bit1 clear overflow, bit2 irq_en
//                     reads return {5'b0, irq_en, 2'b0}
//     +3 OVFCNT (RO)  dropped-character count, saturating
//
//   Optional feature: define KB_IRQ_EN to implement irq_en / irq_pend and a
//   registered kb_irq output. Without it kb_irq is tied low and CTRL bit2
//   is ignored.
//
// Ports
//   clk, reset     system clock; synchronous active-high reset
//   io_addr/io_rd/io_wr/io_wdata   CPU request (1-cycle rd/wr pulses)
//   io_rdata/io_ready              read data, valid with 1-cycle io_ready
//   io_busy                        no request accepted this cycle
//   KB_read_en/KB_clear            pop / flush pulses to keyboard_buf
//   KB_status/KB_data/buf_full     keyboard_buf state
//   rx_done                        receiver delivering a byte (monitored)
//   kb_irq                         level interrupt
// ---------------------------------------------------------------------------
module kb_io_ctrl #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFF00,
    parameter int                OVF_CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [7:0]        io_wdata,
    output logic [7:0]        io_rdata,
    output logic              io_ready,
    output logic              io_busy,
    output logic              KB_read_en,
    output logic              KB_clear,
    input  logic              KB_status,
    input  logic [6:0]        KB_data,
    input  logic              buf_full,
    input  logic              rx_done,
    output logic              kb_irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_POP,
        S_SETTLE
    } state_e;

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_DATA   = 2'd1,
        REG_CTRL   = 2'd2,
        REG_OVFCNT = 2'd3
    } reg_sel_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    offset;
    logic                 in_window;
    reg_sel_e             reg_sel;
    logic                 req_valid;
    logic                 is_pop;
    logic                 wr_ctrl;
    logic                 flush_q;
    logic                 ovf_flag;
    logic [OVF_CNT_W-1:0] ovf_cnt;
    logic [7:0]           ovf_cnt_8;
    logic                 ovf_event;
    logic [7:0]           rd_mux;
    logic                 irq_en;
    logic                 irq_pend;
    logic                 unused_wdata;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    // Subtracting the base keeps the window check correct even if the
    // base is not 4-aligned.
    assign offset    = io_addr - BASE_ADDR;
    assign in_window = (offset < ADDR_W'(4));
    assign reg_sel   = reg_sel_e'(offset[1:0]);

    // Simultaneous rd and wr is treated as malformed and dropped.
    assign req_valid = (io_rd ^ io_wr) && !io_busy && in_window;
    assign is_pop    = req_valid && io_rd && (reg_sel == REG_DATA) && KB_status;
    assign wr_ctrl   = req_valid && io_wr && (reg_sel == REG_CTRL);

    // ------------------------------------------------------------------
    // Optional interrupt logic
    // ------------------------------------------------------------------
`ifdef KB_IRQ_EN
    logic kb_irq_q;

    assign irq_pend = irq_en && (KB_status || ovf_flag);
    assign kb_irq   = kb_irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en   <= 1'b0;
            kb_irq_q <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= io_wdata[2];
            kb_irq_q <= irq_pend;
        end
    end

    assign unused_wdata = ^io_wdata[7:3];
`else
    assign irq_en       = 1'b0;
    assign irq_pend     = 1'b0;
    assign kb_irq       = 1'b0;
    assign unused_wdata = ^io_wdata[7:2];
`endif

    // ------------------------------------------------------------------
    // Read data selection
    // ------------------------------------------------------------------
    if (OVF_CNT_W >= 8) begin : g_cnt_trunc
        assign ovf_cnt_8 = ovf_cnt[7:0];
    end else begin : g_cnt_ext
        assign ovf_cnt_8 = {{(8-OVF_CNT_W){1'b0}}, ovf_cnt};
    end

    always_comb begin
        // NOTE: every combinational output gets a default before the case
        // so that no path leaves it unassigned, which would infer a latch.
        rd_mux = 8'h00;
        unique case (reg_sel)
            REG_STATUS: rd_mux = {4'b0, irq_pend, ovf_flag, buf_full, KB_status};
            REG_DATA:   rd_mux = KB_status ? {1'b0, KB_data} : 8'h00;
            REG_CTRL:   rd_mux = {5'b0, irq_en, 2'b0};
            REG_OVFCNT: rd_mux = ovf_cnt_8;
            default:    rd_mux = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    // Reset masks the pop and ready pulses so an aborted POP never
    // overlaps the reset flush on KB_clear.
    always_comb begin
        state_d    = state_q;
        io_ready   = 1'b0;
        KB_read_en = 1'b0;
        KB_clear   = reset;
        io_busy    = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (is_pop)         state_d = S_POP;
                else if (req_valid) state_d = S_ACK;
            end
            S_ACK: begin
                io_ready = !reset;
                KB_clear = reset || flush_q;
                state_d  = S_IDLE;
            end
            S_POP: begin
                io_ready   = !reset;
                KB_read_en = !reset;
                state_d    = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // An arriving byte is lost only if the buffer is full and no pop frees
    // a slot in the same cycle.
    assign ovf_event = rx_done && buf_full && !KB_read_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            io_rdata <= 8'h00;
            flush_q  <= 1'b0;
            ovf_flag <= 1'b0;
            ovf_cnt  <= '0;
        end else begin
            if (req_valid && io_rd) io_rdata <= rd_mux;

            // Only meaningful in the ACK cycle that follows the accept edge.
            flush_q <= wr_ctrl && io_wdata[0];

            // A clear request takes priority over a coincident overflow.
            if (wr_ctrl && io_wdata[1]) begin
                ovf_flag <= 1'b0;
                ovf_cnt  <= '0;
            end else if (ovf_event) begin
                ovf_flag <= 1'b1;
                if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
            end
        end
    end

endmodule
